sync_countn: RTL
================

SYNC_COUNTN -- requirements
Module: sync_countn

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter width in bits (2..32).
REQ-002 SHALL have parameter MIN_VAL, default 0, meaning the lower count limit.
REQ-003 SHALL have parameter MAX_VAL, default 255, meaning the upper count limit; MIN_VAL < MAX_VAL <= 2^WIDTH-1.
REQ-004 SHALL have parameter RESET_VAL, default 0, meaning the count after reset; MIN_VAL <= RESET_VAL <= MAX_VAL.
REQ-005 SHALL have port mclk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-006 SHALL have port preset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port load, input, 1 bit: synchronous load strobe, active-high.
REQ-008 SHALL have port en, input, 1 bit: count enable, active-high.
REQ-009 SHALL have port updown, input, 1 bit: direction, 1 = up, 0 = down.
REQ-010 SHALL have port data_in, input, WIDTH bits: load value.
REQ-011 SHALL have port data_out, output, WIDTH bits: registered count.
REQ-012 SHALL have port tc, output, 1 bit: combinational terminal-count indication.
REQ-013 SHALL have port wrap, output, 1 bit: registered one-cycle boundary-event pulse.
REQ-014 SHALL have port ovf, output, 1 bit: registered sticky boundary-event flag.

Function
REQ-015 Priority SHALL be preset (async) > load > en > hold.
REQ-016 load=1: data_out SHALL take data_in clamped to [MIN_VAL, MAX_VAL] at the next edge; ovf SHALL clear; wrap SHALL be 0; en and updown are ignored.
REQ-017 load=0, en=1, updown=1, data_out<MAX_VAL: data_out SHALL increment by 1.
REQ-018 load=0, en=1, updown=0, data_out>MIN_VAL: data_out SHALL decrement by 1.
REQ-019 Boundary event SHALL be en=1, load=0, and either (updown=1, data_out==MAX_VAL) or (updown=0, data_out==MIN_VAL).
REQ-020 On a boundary event, data_out SHALL wrap MAX_VAL->MIN_VAL (up) or MIN_VAL->MAX_VAL (down), unless overridden per REQ-028.
REQ-021 wrap SHALL be 1 for exactly the cycle after a boundary event and 0 otherwise.
REQ-022 ovf SHALL set on a boundary event and remain set until load or preset.
REQ-023 tc SHALL equal the boundary-event condition, combinationally from en, load, updown and data_out, with zero latency.
REQ-024 en=0 and load=0: data_out, ovf SHALL hold; wrap SHALL be 0.
REQ-025 Changing updown mid-count SHALL take effect at the next edge, with no lost or extra step.
REQ-026 Internal arithmetic SHALL be WIDTH+1 bits, so that MAX_VAL = 2^WIDTH-1 wraps without truncation error.

Reset
REQ-027 While preset=0, data_out SHALL be RESET_VAL, wrap=0 and ovf=0, asynchronously; the first count SHALL occur on the first mclk rising edge after preset deasserts, including when preset is asserted mid-count.

Configuration
REQ-028 Macro SYNC_COUNTN_SAT_EN defined: a boundary event SHALL hold data_out at the limit (saturate) while still pulsing wrap and setting ovf; undefined: wrap-around per REQ-020.

Verification
REQ-029 Wrap-up, WIDTH=8, MIN=10, MAX=20: load 19, en=1, up -> data_out 20, then 10; tc=1 while at 20; wrap=1 one cycle; ovf=1.
REQ-030 Wrap-down, same parameters: load 11, down -> 10, then 20; wrap pulse; ovf=1.
REQ-031 Clamp: load data_in=5 -> data_out 10; load data_in=200 -> data_out 20; ovf=0 after each load.
REQ-032 Priority: load=1 and en=1 together with data_in=15 -> data_out 15 with no increment; en=0 for 3 cycles -> data_out holds 15.
REQ-033 Async reset: assert preset between edges while data_out=17 -> data_out=RESET_VAL immediately, wrap=0, ovf=0.
REQ-034 SAT build (SYNC_COUNTN_SAT_EN defined): count up to 20 with en held high -> data_out stays 20, wrap pulses each cycle, ovf=1.

Source files
------------

// File: rtl/sync_countn.sv
// Parameterised up/down counter over [MIN_VAL, MAX_VAL] with clamped load, terminal count,
// wrap pulse and sticky overflow. Define SYNC_COUNTN_SAT_EN to saturate at the limits instead of wrapping.
module sync_countn #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = 255,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             mclk,
    input  logic             preset,
    input  logic             load,
    input  logic             en,
    input  logic             updown,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // One guard bit so that MAX_VAL = 2^WIDTH-1 plus one is still visible as out of range.
    localparam logic [WIDTH:0]   MIN_E = {1'b0, WIDTH'(MIN_VAL)};
    localparam logic [WIDTH:0]   MAX_E = {1'b0, WIDTH'(MAX_VAL)};
    localparam logic [WIDTH:0]   ONE_E = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   din_ext;
    logic [WIDTH:0]   nxt;
    logic [WIDTH:0]   din_clamp;
    logic             bnd;

    always_comb begin
        cnt_ext = {1'b0, cnt_q};
        din_ext = {1'b0, data_in};
        nxt     = updown ? (cnt_ext + ONE_E) : (cnt_ext - ONE_E);

        din_clamp = din_ext;
        if (din_ext <= MIN_E)
            din_clamp = MIN_E;
        else if (din_ext > MAX_E)
            din_clamp = MAX_E;

        bnd = en && !load && (updown ? (nxt > MAX_E) : (cnt_ext == MIN_E));
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (load) begin
            cnt_d = din_clamp[WIDTH-1:0];
            ovf_d = 1'b0;
        end else if (en) begin
            if (bnd) begin
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
`ifdef SYNC_COUNTN_SAT_EN
                cnt_d  = cnt_q;
`else
                cnt_d  = updown ? MIN_E[WIDTH-1:0] : MAX_E[WIDTH-1:0];
`endif
            end else begin
                cnt_d = nxt[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge mclk or negedge preset) begin
        if (!preset) begin
            cnt_q  <= RST_V;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_out = cnt_q;
    assign tc       = bnd;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;

endmodule
